// File: rtl/aes_round_key_sequencer.sv
// aes_round_key_sequencer
//   Control FSM in front of the combinational round-key generator
//   (key_module256). It latches a cipher key and mode, then walks round index
//   round_idx over 0..Nr, registers each generated round key and offers it to
//   the round datapath over a valid/ready handshake.
//
//   Optional feature macro: DECRYPT_ORDER_EN
//     defined   : adds input `decrypt` (sampled with start); decrypt=1 walks
//                 the index from Nr down to 0 instead of 0 up to Nr.
//     undefined : no decrypt port, ascending order only.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   start, abort  begin schedule (IDLE only) / cancel schedule (non-IDLE)
//   key_in        cipher key (128/192-bit keys left-aligned), sampled with start
//   algorithm_in  00=AES-128, 10=AES-192, 01=AES-256, 11=illegal
//   key_out       latched key        -> key_module256.key
//   algorithm     latched mode       -> key_module256.Algorithm
//   round_idx     round index        -> key_module256.i
//   rk_in         generated key      <- key_module256.out
//   round_key     registered round key, rk_valid / rk_ready handshake
//   last_round    with rk_valid on the final index of the schedule
//   busy          any state but IDLE
//   done          one-cycle pulse after the final key is accepted
//   err           one-cycle pulse after start with an illegal mode
module aes_round_key_sequencer #(
  parameter int unsigned KEY_W = 256,
  parameter int unsigned BLK_W = 128,
  parameter int unsigned IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [KEY_W-1:0] key_in,
  input  logic [1:0]       algorithm_in,
`ifdef DECRYPT_ORDER_EN
  input  logic             decrypt,
`endif
  output logic [KEY_W-1:0] key_out,
  output logic [1:0]       algorithm,
  output logic [IDX_W-1:0] round_idx,
  input  logic [BLK_W-1:0] rk_in,
  output logic [BLK_W-1:0] round_key,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic             last_round,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_PRESENT,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic             desc;        // latched direction: 1 = descending index
  logic             desc_start;  // direction requested with start
  logic             legal_start;
  logic             kill;        // abort wins over any handshake
  logic [IDX_W-1:0] final_idx;
  logic             at_final;

  function automatic logic [IDX_W-1:0] nr_of(input logic [1:0] alg);
    case (alg)
      2'b10:   return IDX_W'(12);
      2'b01:   return IDX_W'(14);
      default: return IDX_W'(10);
    endcase
  endfunction

`ifdef DECRYPT_ORDER_EN
  assign desc_start = decrypt;
`else
  assign desc_start = 1'b0;
`endif

  assign legal_start = start && (algorithm_in != 2'b11);
  assign kill        = abort && (state != S_IDLE);
  assign final_idx   = desc ? '0 : nr_of(algorithm);
  assign at_final    = (round_idx == final_idx);

  assign rk_valid   = (state == S_PRESENT);
  assign last_round = rk_valid && at_final;
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (legal_start) state_nxt = S_FETCH;
      S_FETCH:   state_nxt = S_PRESENT;
      S_PRESENT: if (rk_ready) state_nxt = at_final ? S_DONE : S_FETCH;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
    if (kill) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      key_out   <= '0;
      algorithm <= '0;
      round_idx <= '0;
      round_key <= '0;
      desc      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state <= state_nxt;
      err   <= (state == S_IDLE) && start && (algorithm_in == 2'b11);
      if (kill) begin
        round_idx <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (legal_start) begin
              key_out   <= key_in;
              algorithm <= algorithm_in;
              desc      <= desc_start;
              round_idx <= desc_start ? nr_of(algorithm_in) : '0;
            end
          end
          // key_module256 has had a full cycle to settle on the new index
          S_FETCH: round_key <= rk_in;
          S_PRESENT: begin
            if (rk_ready && !at_final)
              round_idx <= desc ? (round_idx - IDX_W'(1)) : (round_idx + IDX_W'(1));
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aes_round_key_sequencer.sv
module tb_aes_round_key_sequencer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [255:0] key_in = '0;
  logic [1:0]   algorithm_in = 2'b00;
  logic         decrypt_s = 1'b0;
  logic [255:0] key_out;
  logic [1:0]   algorithm;
  logic [3:0]   round_idx;
  logic [127:0] rk_in;
  logic [127:0] round_key;
  logic         rk_valid;
  logic         rk_ready = 1'b1;
  logic         last_round, busy, done, err;

  aes_round_key_sequencer #(.KEY_W(256), .BLK_W(128), .IDX_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .key_in(key_in), .algorithm_in(algorithm_in),
`ifdef DECRYPT_ORDER_EN
    .decrypt(decrypt_s),
`endif
    .key_out(key_out), .algorithm(algorithm), .round_idx(round_idx),
    .rk_in(rk_in), .round_key(round_key), .rk_valid(rk_valid), .rk_ready(rk_ready),
    .last_round(last_round), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // ---------------- AES key expansion (reference key_module256) ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] t = x;
    logic [7:0] r = 8'h01;
    logic [7:0] s;
    for (int i = 1; i < 8; i++) begin  // x^254 = x^2 * x^4 * ... * x^128
      t = gmul(t, t);
      r = gmul(r, t);
    end
    s = r ^ 8'h63;
    for (int i = 1; i <= 4; i++) begin
      r = {r[6:0], r[7]};
      s = s ^ r;
    end
    return s;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] model_rk(input logic [255:0] k, input logic [1:0] a,
                                            input logic [3:0] idx);
    logic [31:0] w [64];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    int          nk;
    nk = (a == 2'b10) ? 6 : (a == 2'b01) ? 8 : 4;
    for (int j = 0; j < nk; j++) w[j] = k[255-32*j -: 32];
    for (int i = nk; i < 64; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk == 8 && i % nk == 4) begin
        t = subword(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    return {w[4*idx], w[4*idx+1], w[4*idx+2], w[4*idx+3]};
  endfunction

  always_comb rk_in = model_rk(key_out, algorithm, round_idx);

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [3:0]   idx;
    logic [127:0] key;
    logic         last;
  } ent_t;

  ent_t         q[$];
  logic         m_init = 1'b0;
  logic         active = 1'b0, valid_e = 1'b0, done_e = 1'b0, err_e = 1'b0;
  logic [255:0] key_e = '0;
  logic [1:0]   alg_e = 2'b00;
  logic [3:0]   idx_e = '0;

  // Inputs change only just after posedge, so at negedge they are exactly
  // what the coming posedge will sample: compare, then advance the model.
  always @(negedge clk) begin
    logic pd;
    logic dn;
    int   nr;
    if (m_init) begin
      chk("rk_valid", rk_valid, valid_e);
      chk("busy", busy, active || done_e);
      chk("done", done, done_e);
      chk("err", err, err_e);
      chk("round_idx", round_idx, idx_e);
      chk("key_out", key_out, key_e);
      chk("algorithm", algorithm, alg_e);
      chk("last_round", last_round, valid_e && q[0].last);
      if (valid_e) chk("round_key", round_key, q[0].key);
      if (done) done_cnt++;
    end
    pd = done_e;
    err_e = 1'b0;
    done_e = 1'b0;
    if (rst) begin
      active = 0; valid_e = 0; q.delete(); key_e = '0; alg_e = 2'b00; idx_e = '0;
      m_init = 1'b1;
    end else if (pd) begin
      // final cycle of a schedule: returns to idle, start not accepted yet
    end else if (active) begin
      if (abort) begin
        active = 0; valid_e = 0; q.delete(); idx_e = '0;
      end else if (!valid_e) begin
        valid_e = 1'b1;
      end else if (rk_ready) begin
        void'(q.pop_front());
        valid_e = 1'b0;
        if (q.size() == 0) begin
          active = 1'b0;
          done_e = 1'b1;
        end else begin
          idx_e = q[0].idx;
        end
      end
    end else if (start) begin
      if (algorithm_in == 2'b11) begin
        err_e = 1'b1;
      end else begin
`ifdef DECRYPT_ORDER_EN
        dn = decrypt_s;
`else
        dn = 1'b0;
`endif
        nr = (algorithm_in == 2'b10) ? 12 : (algorithm_in == 2'b01) ? 14 : 10;
        key_e = key_in;
        alg_e = algorithm_in;
        for (int i = 0; i <= nr; i++) begin
          ent_t e;
          e.idx  = 4'(dn ? nr - i : i);
          e.key  = model_rk(key_in, algorithm_in, e.idx);
          e.last = (i == nr);
          q.push_back(e);
        end
        idx_e = q[0].idx;
        active = 1'b1;
        valid_e = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic go(input logic [255:0] k, input logic [1:0] a);
    key_in = k; algorithm_in = a; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idx(input logic [3:0] i, input string nm);
    for (int c = 0; c < 100; c++) begin
      if (rk_valid && round_idx == i) break;
      tick();
    end
    chk(nm, rk_valid && round_idx == i, 1);
  endtask

  task automatic wait_idle(input string nm);
    for (int c = 0; c < 200; c++) begin
      if (!busy) break;
      tick();
    end
    chk(nm, busy, 0);
  endtask

  logic [255:0] rk256;

  initial begin
    int n;
    int d0;
    // pin the reference key expansion against known FIPS-197 values
    chk("pin256_0",  model_rk(K256, 2'b01, 4'd0),  128'h000102030405060708090a0b0c0d0e0f);
    chk("pin256_1",  model_rk(K256, 2'b01, 4'd1),  128'h101112131415161718191a1b1c1d1e1f);
    chk("pin256_14", model_rk(K256, 2'b01, 4'd14), 128'h24fc79ccbf0979e9371ac23c6d68de36);
    chk("pin128_10", model_rk(K128, 2'b00, 4'd10), 128'h13111d7fe3944a17f307a78b4d2b30c5);

    tick(); tick();
    chk("reset_round_key", round_key, '0);
    chk("reset_busy", busy, 0);
    rst = 1'b0;
    tick();

    // 1: AES-256, ready high, done latency
    rk_ready = 1'b1;
    key_in = K256; algorithm_in = 2'b01; start = 1'b1;
    tick(); n = 1; start = 1'b0;
    while (!done && n < 100) begin tick(); n++; end
    chk("t1_done_latency", n, 31);
    chk("t1_last_key", round_key, 128'h24fc79ccbf0979e9371ac23c6d68de36);
    tick(); tick();

    // 2: AES-128, exactly one done pulse
    d0 = done_cnt;
    go(K128, 2'b00);
    wait_idle("t2_idle");
    tick(); tick();
    chk("t2_done_pulses", done_cnt - d0, 1);
    chk("t2_last_key", round_key, 128'h13111d7fe3944a17f307a78b4d2b30c5);

    // 3: backpressure at idx 3
    go(K256, 2'b10);
    wait_idx(4'd3, "t3_reach_idx3");
    rk_ready = 1'b0;
    repeat (5) tick();
    chk("t3_held_valid", rk_valid, 1);
    chk("t3_held_idx", round_idx, 3);
    rk_ready = 1'b1;
    wait_idle("t3_idle");
    tick();

    // 4: illegal algorithm
    go(K256, 2'b11);
    chk("t4_err", err, 1);
    chk("t4_busy", busy, 0);
    tick();
    chk("t4_err_gone", err, 0);

    // 5: abort at idx 7, reset mid-schedule, start while busy
    go(K256, 2'b01);
    wait_idx(4'd7, "t5_reach_idx7");
    abort = 1'b1; tick(); abort = 1'b0;
    chk("t5_abort_idle", busy, 0);
    chk("t5_abort_idx", round_idx, 0);
    go(K128, 2'b00);
    repeat (6) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t5_rst_round_key", round_key, '0);
    chk("t5_rst_key_out", key_out, '0);
    tick();
    go(K256, 2'b01);
    repeat (3) tick();
    go(~K256, 2'b00);
    chk("t5_ignored_start_key", key_out, K256);
    wait_idle("t5_idle");
    tick();

`ifdef DECRYPT_ORDER_EN
    // 6: decrypt order
    decrypt_s = 1'b1;
    go(K256, 2'b01);
    wait_idx(4'd14, "t6_first_idx14");
    chk("t6_first_key", round_key, 128'h24fc79ccbf0979e9371ac23c6d68de36);
    wait_idx(4'd0, "t6_last_idx0");
    chk("t6_last_key", round_key, 128'h000102030405060708090a0b0c0d0e0f);
    chk("t6_last_round", last_round, 1);
    wait_idle("t6_idle");
    decrypt_s = 1'b0;
    tick();
`endif

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      start        = ($urandom % 4) == 0;
      algorithm_in = 2'($urandom);
      for (int j = 0; j < 8; j++) rk256[32*j +: 32] = $urandom;
      key_in       = rk256;
      rk_ready     = ($urandom % 10) < 7;
      abort        = ($urandom % 64) == 0;
      rst          = ($urandom % 400) == 0;
      decrypt_s    = 1'($urandom);
      tick();
    end
    start = 1'b0; abort = 1'b0; rst = 1'b0; rk_ready = 1'b1;
    wait_idle("rand_idle");
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
